if_stage: RTL and testbench

- Instruction-fetch front end. Owns the PC, drives the synchronous instruction ROM, and holds the IF/ID pipeline register.
- Consumes the pipeline-control outputs: global hold, PC/IF-ID hold, jump enable and address, and the IF/ID flush.
- Must deliver exactly one valid instruction per unstalled cycle. Stalls and redirects must cause no instruction loss or duplication, even though ROM read data arrives one cycle after the address.

---
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction-fetch front end (PC, ROM request, skid, IF/ID register)
// Rev 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic              clk_100MHz,
    input  logic              arst_n,
    input  logic              hold_ena_i,
    input  logic              pc_hold_i,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              pc_id_clr_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [31:0]       id_inst_o,
    output logic              id_valid_o
);

    logic [ADDR_W-1:0] fetch_pc;
    logic              issued_v;
    logic [ADDR_W-1:0] issued_pc;
    logic              sk_v;
    logic [ADDR_W-1:0] sk_pc;
    logic [31:0]       sk_inst;

    logic redirect;
    logic freeze;

    assign redirect = jump_ena_i | pc_id_clr_i;
    // Global hold outranks redirects; the data-hazard hold does not.
    assign freeze   = hold_ena_i | (pc_hold_i & ~redirect);

    always_comb begin
        rom_ce_o   = 1'b0;
        rom_addr_o = fetch_pc;
        if (!arst_n) begin
            rom_ce_o   = 1'b0;
            rom_addr_o = RESET_PC;
        end else if (!freeze) begin
            rom_ce_o = 1'b1;
            if (jump_ena_i) begin
                rom_addr_o = jump_addr_i;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            fetch_pc   <= RESET_PC;
            issued_v   <= 1'b0;
            issued_pc  <= '0;
            sk_v       <= 1'b0;
            sk_pc      <= '0;
            sk_inst    <= NOP_INST;
            id_pc_o    <= '0;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end else if (freeze) begin
            // Park the returning read so it is not lost while nothing moves.
            if (issued_v) begin
                sk_v     <= 1'b1;
                sk_pc    <= issued_pc;
                sk_inst  <= rom_data_i;
                issued_v <= 1'b0;
            end
        end else begin
            issued_v <= 1'b1;
            sk_v     <= 1'b0;
            if (jump_ena_i) begin
                issued_pc <= jump_addr_i;
                fetch_pc  <= jump_addr_i + ADDR_W'(4);
            end else begin
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + ADDR_W'(4);
            end

            if (redirect) begin
                id_pc_o    <= '0;
                id_inst_o  <= NOP_INST;
                id_valid_o <= 1'b0;
            end else if (sk_v) begin
                id_pc_o    <= sk_pc;
                id_inst_o  <= sk_inst;
                id_valid_o <= 1'b1;
            end else if (issued_v) begin
                id_pc_o    <= issued_pc;
                id_inst_o  <= rom_data_i;
                id_valid_o <= 1'b1;
            end else begin
                id_pc_o    <= '0;
                id_inst_o  <= NOP_INST;
                id_valid_o <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed vectors plus a stream-level model of the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        hold, pch, jmp, clr;
    logic [31:0] ja;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic [31:0] id_pc, id_inst;
    logic        id_valid;

    int vectors     = 0;
    int miscompares = 0;

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk_100MHz (clk),
        .arst_n     (arst_n),
        .hold_ena_i (hold),
        .pc_hold_i  (pch),
        .jump_ena_i (jmp),
        .jump_addr_i(ja),
        .pc_id_clr_i(clr),
        .rom_ce_o   (rom_ce),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst),
        .id_valid_o (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    always @(posedge clk) if (rom_ce) rom_data <= rom_word(rom_addr);

    // Stream model: s_pc is the next address owed to decode; primed says a
    // fetch for it is already outstanding (in flight or parked).
    logic [31:0] s_pc    = RST_PC;
    logic        primed  = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_inst  = NOP;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_pc = RST_PC; primed = 1'b0;
            m_pc = '0; m_inst = NOP; m_valid = 1'b0;
        end else if (hold) begin
        end else if (jmp || clr) begin
            if (jmp)         s_pc = ja;
            else if (primed) s_pc = s_pc + 32'd4;
            primed = 1'b1;
            m_pc = '0; m_inst = NOP; m_valid = 1'b0;
        end else if (pch) begin
        end else if (primed) begin
            m_pc = s_pc; m_inst = rom_word(s_pc); m_valid = 1'b1;
            s_pc = s_pc + 32'd4;
        end else begin
            m_pc = '0; m_inst = NOP; m_valid = 1'b0;
            primed = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic        e_ce;
        logic [31:0] e_addr;
        e_ce   = arst_n && !hold && (jmp || clr || !pch);
        e_addr = !arst_n ? RST_PC : jmp ? ja : (primed ? s_pc + 32'd4 : s_pc);
        vectors++;
        if (id_pc !== m_pc || id_inst !== m_inst || id_valid !== m_valid ||
            rom_ce !== e_ce || ((e_ce || !arst_n) && rom_addr !== e_addr)) begin
            miscompares++;
            $display("FAIL cycle@%0t: got pc=%h inst=%h v=%b ce=%b addr=%h expected pc=%h inst=%h v=%b ce=%b addr=%h",
                     $time, id_pc, id_inst, id_valid, rom_ce, rom_addr,
                     m_pc, m_inst, m_valid, e_ce, e_addr);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        lit({tag, "_pc"},    id_pc, 32'h0);
        lit({tag, "_inst"},  id_inst, NOP);
        lit({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
        lit({tag, "_ce"},    {31'b0, rom_ce}, 32'h0);
        lit({tag, "_addr"},  rom_addr, 32'hFFFF_FFF8);
    endtask

    initial begin
        arst_n = 1'b1; hold = 0; pch = 0; jmp = 0; clr = 0; ja = '0;
        #1 arst_n = 1'b0;
        #2 check_reset_state("reset");
        tick; tick;
        arst_n = 1'b1;

        tick; tick;
        lit("first_pc", id_pc, 32'hFFFF_FFF8);
        lit("first_inst", id_inst, 32'h4000_0FFE);
        lit("first_valid", {31'b0, id_valid}, 32'h1);
        tick; lit("seq_fffc", id_pc, 32'hFFFF_FFFC);
        tick; lit("wrap_0", id_pc, 32'h0);
        lit("wrap_0_inst", id_inst, 32'h0000_1000);
        tick; lit("seq_4", id_pc, 32'h4);
        tick; lit("seq_8", id_pc, 32'h8);

        pch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            lit("stall_hold_8", id_pc, 32'h8);
        end
        pch = 1'b0;
        tick; lit("skid_c", id_pc, 32'hC);
        lit("skid_c_inst", id_inst, 32'h0000_1003);
        tick; lit("after_skid_10", id_pc, 32'h10);

        jmp = 1'b1; clr = 1'b1; ja = 32'h100;
        tick;
        lit("flush_valid", {31'b0, id_valid}, 32'h0);
        lit("flush_inst", id_inst, NOP);
        jmp = 1'b0; clr = 1'b0;
        tick; lit("jump_100", id_pc, 32'h100);
        lit("jump_100_inst", id_inst, 32'h0000_1040);
        tick; lit("jump_104", id_pc, 32'h104);

        hold = 1'b1; jmp = 1'b1; ja = 32'h200;
        #1 lit("hold_ce_off", {31'b0, rom_ce}, 32'h0);
        tick; lit("hold_keep_104a", id_pc, 32'h104);
        tick; lit("hold_keep_104b", id_pc, 32'h104);
        hold = 1'b0;
        #1 lit("release_ce", {31'b0, rom_ce}, 32'h1);
        lit("release_addr", rom_addr, 32'h200);
        tick; lit("redirect_bubble", {31'b0, id_valid}, 32'h0);
        jmp = 1'b0;
        tick; lit("redirect_200", id_pc, 32'h200);
        tick; lit("redirect_204", id_pc, 32'h204);

        pch = 1'b1;
        tick; tick;
        #2 arst_n = 1'b0;
        #1 check_reset_state("mid_stall_reset");
        tick;
        pch = 1'b0; arst_n = 1'b1;
        tick; tick;
        lit("restart_pc", id_pc, 32'hFFFF_FFF8);
        lit("restart_valid", {31'b0, id_valid}, 32'h1);
        tick; lit("restart_fffc", id_pc, 32'hFFFF_FFFC);
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
